// File: rtl/rcpu_mem_arbiter.sv
// Shares RCPU memory between the CPU (absolute priority, zero added latency) and a loader port; BOOT mode holds the CPU in reset.
// Grants are combinational in the issue cycle, loader read data returns 1 cycle later; optional RCPU_ARB_STATS_EN adds ldr_wait_cnt.
module rcpu_mem_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int BOOT_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          cpu_resetq,
  input  logic          cpu_rd_en,
  input  logic [AW-1:0] cpu_rd_addr,
  output logic [DW-1:0] cpu_rd_data,
  input  logic          cpu_wr_en,
  input  logic [AW-1:0] cpu_wr_addr,
  input  logic [DW-1:0] cpu_wr_data,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  input  logic          ldr_done,
  input  logic          boot_req,
  output logic          mode_boot,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data
`ifdef RCPU_ARB_STATS_EN
  ,
  output logic [15:0]   ldr_wait_cnt
`endif
);

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_BOOT = 1'b1
  } mode_e;

  localparam mode_e RESET_MODE = (BOOT_ON_RESET != 0) ? MODE_BOOT : MODE_RUN;

  mode_e mode_q;
  logic  rvalid_q;
  logic  boot;
  logic  cpu_rd_sel;
  logic  cpu_wr_sel;
  logic  ldr_rd_gnt;
  logic  ldr_wr_gnt;

  assign boot = (mode_q == MODE_BOOT);

  // Everything is gated by reset so nothing reaches the RAM while reset is held.
  assign cpu_rd_sel = ~reset & ~boot & cpu_rd_en;
  assign cpu_wr_sel = ~reset & ~boot & cpu_wr_en;
  assign ldr_rd_gnt = ~reset & ldr_req & ~ldr_we & (boot | ~cpu_rd_en);
  assign ldr_wr_gnt = ~reset & ldr_req &  ldr_we & (boot | ~cpu_wr_en);

  assign ldr_gnt     = ldr_rd_gnt | ldr_wr_gnt;
  assign mem_rd_en   = cpu_rd_sel | ldr_rd_gnt;
  assign mem_rd_addr = cpu_rd_sel ? cpu_rd_addr : ldr_addr;
  assign mem_wr_en   = cpu_wr_sel | ldr_wr_gnt;
  assign mem_wr_addr = cpu_wr_sel ? cpu_wr_addr : ldr_addr;
  assign mem_wr_data = cpu_wr_sel ? cpu_wr_data : ldr_wdata;

  assign cpu_rd_data = mem_rd_data;
  assign ldr_rdata   = mem_rd_data;
  assign mode_boot   = boot;
  assign cpu_resetq  = ~boot;
  // A read granted just before reset must not surface while reset is held.
  assign ldr_rvalid  = rvalid_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= RESET_MODE;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= ldr_rd_gnt;
      case (mode_q)
        MODE_BOOT: if (ldr_done && !boot_req) mode_q <= MODE_RUN;
        MODE_RUN:  if (boot_req) mode_q <= MODE_BOOT;
        default:   mode_q <= RESET_MODE;
      endcase
    end
  end

`ifdef RCPU_ARB_STATS_EN
  logic [15:0] wait_cnt_q;
  logic [15:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (boot_req) begin
      wait_cnt_d = 16'h0000;
    end else if (ldr_req && !ldr_gnt && (wait_cnt_q != 16'hFFFF)) begin
      wait_cnt_d = wait_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 16'h0000;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign ldr_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// Bench for rcpu_mem_arbiter: vector table for grant/mux decisions, hand sequences for mode and reset corners.
module tb_rcpu_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_resetq;
  logic        cpu_rd_en;
  logic [15:0] cpu_rd_addr;
  logic [15:0] cpu_rd_data;
  logic        cpu_wr_en;
  logic [15:0] cpu_wr_addr;
  logic [15:0] cpu_wr_data;
  logic        ldr_req;
  logic        ldr_we;
  logic [15:0] ldr_addr;
  logic [15:0] ldr_wdata;
  logic        ldr_gnt;
  logic        ldr_rvalid;
  logic [15:0] ldr_rdata;
  logic        ldr_done;
  logic        boot_req;
  logic        mode_boot;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
`ifdef RCPU_ARB_STATS_EN
  logic [15:0] ldr_wait_cnt;
`endif

  rcpu_mem_arbiter #(.AW(16), .DW(16), .BOOT_ON_RESET(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_resetq  (cpu_resetq),
    .cpu_rd_en   (cpu_rd_en),
    .cpu_rd_addr (cpu_rd_addr),
    .cpu_rd_data (cpu_rd_data),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_wr_addr (cpu_wr_addr),
    .cpu_wr_data (cpu_wr_data),
    .ldr_req     (ldr_req),
    .ldr_we      (ldr_we),
    .ldr_addr    (ldr_addr),
    .ldr_wdata   (ldr_wdata),
    .ldr_gnt     (ldr_gnt),
    .ldr_rvalid  (ldr_rvalid),
    .ldr_rdata   (ldr_rdata),
    .ldr_done    (ldr_done),
    .boot_req    (boot_req),
    .mode_boot   (mode_boot),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
`ifdef RCPU_ARB_STATS_EN
    ,
    .ldr_wait_cnt(ldr_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: registered read (read-before-write on the same address)
  logic [15:0] ram [0:65535];
  logic [15:0] ram_rd_q;
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) ram_rd_q <= mem_rd_data_next();
  end
  function automatic logic [15:0] mem_rd_data_next();
    return ram[mem_rd_addr];
  endfunction
  assign mem_rd_data = ram_rd_q;

  logic [15:0] exp_mem [0:65535];
  logic [15:0] ldr_q [$];
  logic [15:0] cpu_q [$];
  logic        cpu_due_nxt;
  logic        cpu_due;
  int          errors;
  int          checks;

  typedef struct packed {
    logic boot;
    logic cre;
    logic cwe;
    logic lreq;
    logic lwe;
    logic exp_gnt;
    logic exp_mre;
    logic exp_rcpu;
    logic exp_mwe;
    logic exp_wcpu;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cpu_due <= cpu_due_nxt;

  always @(negedge clk) begin
    if (ldr_rvalid) begin
      if (ldr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ldr_rvalid_unexpected: got 1 expected 0");
      end else begin
        chk("ldr_rdata", {16'h0, ldr_rdata}, {16'h0, ldr_q.pop_front()});
      end
    end
    if (cpu_due) begin
      if (cpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_q_empty: got 0 expected 1");
      end else begin
        chk("cpu_rd_data", {16'h0, cpu_rd_data}, {16'h0, cpu_q.pop_front()});
      end
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cpu_rd_en   = 1'b0;
    cpu_rd_addr = 16'h0;
    cpu_wr_en   = 1'b0;
    cpu_wr_addr = 16'h0;
    cpu_wr_data = 16'h0;
    ldr_req     = 1'b0;
    ldr_we      = 1'b0;
    ldr_addr    = 16'h0;
    ldr_wdata   = 16'h0;
    ldr_done    = 1'b0;
    boot_req    = 1'b0;
    cpu_due_nxt = 1'b0;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      begin_cycle();
      cpu_rd_en   = tbl[i].cre;
      cpu_rd_addr = 16'h0020;
      cpu_wr_en   = tbl[i].cwe;
      cpu_wr_addr = 16'h0021;
      cpu_wr_data = 16'h1000 + 16'(i);
      ldr_req     = tbl[i].lreq;
      ldr_we      = tbl[i].lwe;
      ldr_addr    = 16'h0022;
      ldr_wdata   = 16'h2000 + 16'(i);
      #3;
      chk($sformatf("tbl%0d_gnt", i), {31'h0, ldr_gnt}, {31'h0, tbl[i].exp_gnt});
      chk($sformatf("tbl%0d_resetq", i), {31'h0, cpu_resetq}, {31'h0, ~tbl[i].boot});
      chk($sformatf("tbl%0d_mre", i), {31'h0, mem_rd_en}, {31'h0, tbl[i].exp_mre});
      chk($sformatf("tbl%0d_mwe", i), {31'h0, mem_wr_en}, {31'h0, tbl[i].exp_mwe});
      if (tbl[i].exp_mre) begin
        chk($sformatf("tbl%0d_raddr", i), {16'h0, mem_rd_addr},
            tbl[i].exp_rcpu ? 32'h0020 : 32'h0022);
        if (tbl[i].exp_rcpu) begin
          cpu_q.push_back(exp_mem[16'h0020]);
          cpu_due_nxt = 1'b1;
        end else begin
          ldr_q.push_back(exp_mem[16'h0022]);
        end
      end
      if (tbl[i].exp_mwe) begin
        chk($sformatf("tbl%0d_waddr", i), {16'h0, mem_wr_addr},
            tbl[i].exp_wcpu ? 32'h0021 : 32'h0022);
        chk($sformatf("tbl%0d_wdata", i), {16'h0, mem_wr_data},
            tbl[i].exp_wcpu ? 32'h1000 + i : 32'h2000 + i);
        if (tbl[i].exp_wcpu) exp_mem[16'h0021] = 16'h1000 + 16'(i);
        else                 exp_mem[16'h0022] = 16'h2000 + 16'(i);
      end
    end
  endtask

  initial begin
    //        boot cre cwe lreq lwe  gnt mre rcpu mwe wcpu
    tbl[0] = {1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[1] = {1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[2] = {1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[3] = {1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b1};
    tbl[4] = {1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0};
    tbl[5] = {1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b1};
    tbl[6] = {1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0};
    tbl[7] = {1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[8] = {1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[9] = {1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1};

    errors = 0;
    checks = 0;
    for (int a = 0; a < 65536; a++) begin
      ram[a]     = 16'h0;
      exp_mem[a] = 16'h0;
    end
    ram_rd_q    = 16'h0;
    cpu_due_nxt = 1'b0;

    // Reset, with a loader write pending that must not reach the RAM
    reset = 1'b1;
    begin_cycle();
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0005; ldr_wdata = 16'hDEAD;
    begin_cycle();
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0005; ldr_wdata = 16'hDEAD;
    #3;
    chk("rst_mode_boot", {31'h0, mode_boot}, 32'h1);
    chk("rst_cpu_resetq", {31'h0, cpu_resetq}, 32'h0);
    chk("rst_gnt", {31'h0, ldr_gnt}, 32'h0);
    chk("rst_rvalid", {31'h0, ldr_rvalid}, 32'h0);
    chk("rst_mre", {31'h0, mem_rd_en}, 32'h0);
    chk("rst_mwe", {31'h0, mem_wr_en}, 32'h0);
    begin_cycle();
    reset = 1'b0;

    run_table(0, 2);

    // Test 1: boot load then CPU fetch
    begin_cycle();
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0005; ldr_wdata = 16'hBEEF;
    #3;
    chk("t1_gnt", {31'h0, ldr_gnt}, 32'h1);
    chk("t1_waddr", {16'h0, mem_wr_addr}, 32'h0005);
    chk("t1_wdata", {16'h0, mem_wr_data}, 32'hBEEF);
    exp_mem[16'h0005] = 16'hBEEF;
    begin_cycle();
    ldr_done = 1'b1;
    #3;
    chk("t1_resetq_done_cycle", {31'h0, cpu_resetq}, 32'h0);
    begin_cycle();
    #3;
    chk("t1_resetq_after", {31'h0, cpu_resetq}, 32'h1);
    chk("t1_mode_run", {31'h0, mode_boot}, 32'h0);
    begin_cycle();
    cpu_rd_en = 1'b1; cpu_rd_addr = 16'h0005;
    cpu_q.push_back(16'hBEEF);
    cpu_due_nxt = 1'b1;
    #3;
    chk("t1_raddr", {16'h0, mem_rd_addr}, 32'h0005);

    run_table(3, 9);

    // Test 2: CPU write wins, loader write follows
    begin_cycle();
    cpu_wr_en = 1'b1; cpu_wr_addr = 16'h0010; cpu_wr_data = 16'h1234;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0011; ldr_wdata = 16'h5678;
    #3;
    chk("t2_gnt_blocked", {31'h0, ldr_gnt}, 32'h0);
    chk("t2_cpu_wdata", {16'h0, mem_wr_data}, 32'h1234);
    exp_mem[16'h0010] = 16'h1234;
    begin_cycle();
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0011; ldr_wdata = 16'h5678;
    #3;
    chk("t2_gnt", {31'h0, ldr_gnt}, 32'h1);
    chk("t2_ldr_waddr", {16'h0, mem_wr_addr}, 32'h0011);
    exp_mem[16'h0011] = 16'h5678;

    // Test 3: loader read, then CPU read of the other location right behind it
    begin_cycle();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0011;
    #3;
    chk("t3_gnt", {31'h0, ldr_gnt}, 32'h1);
    ldr_q.push_back(exp_mem[16'h0011]);
    begin_cycle();
    cpu_rd_en = 1'b1; cpu_rd_addr = 16'h0010;
    cpu_q.push_back(exp_mem[16'h0010]);
    cpu_due_nxt = 1'b1;
    #3;
    chk("t3_rvalid", {31'h0, ldr_rvalid}, 32'h1);
    begin_cycle();
    #3;
    chk("t3_rvalid_drop", {31'h0, ldr_rvalid}, 32'h0);

    // Test 5: granted loader read, reset next cycle
    begin_cycle();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0011;
    #3;
    chk("t5_gnt", {31'h0, ldr_gnt}, 32'h1);
    begin_cycle();
    reset = 1'b1;
    #3;
    chk("t5_rvalid", {31'h0, ldr_rvalid}, 32'h0);
    begin_cycle();
    #3;
    chk("t5_mode_boot", {31'h0, mode_boot}, 32'h1);
    chk("t5_cpu_resetq", {31'h0, cpu_resetq}, 32'h0);
    chk("t5_rvalid_after", {31'h0, ldr_rvalid}, 32'h0);
    begin_cycle();
    reset = 1'b0;
    ldr_done = 1'b1;
    begin_cycle();
    #3;
    chk("t5_back_to_run", {31'h0, mode_boot}, 32'h0);

    // Test 4: CPU read streaming starves the loader read
    for (int c = 0; c < 20; c++) begin
      begin_cycle();
      cpu_rd_en = 1'b1; cpu_rd_addr = 16'h0020;
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0010;
      cpu_q.push_back(exp_mem[16'h0020]);
      cpu_due_nxt = 1'b1;
      #3;
      chk($sformatf("t4_starve%0d", c), {31'h0, ldr_gnt}, 32'h0);
    end
    begin_cycle();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0010;
    #3;
    chk("t4_gnt", {31'h0, ldr_gnt}, 32'h1);
`ifdef RCPU_ARB_STATS_EN
    chk("t4_wait_cnt", {16'h0, ldr_wait_cnt}, 32'd20);
`endif
    ldr_q.push_back(exp_mem[16'h0010]);
    begin_cycle();
    #3;
    chk("t4_rvalid", {31'h0, ldr_rvalid}, 32'h1);

    // Test 6: boot_req beats ldr_done
    begin_cycle();
    boot_req = 1'b1; ldr_done = 1'b1;
    #3;
    chk("t6_still_run", {31'h0, mode_boot}, 32'h0);
    begin_cycle();
    #3;
    chk("t6_mode_boot", {31'h0, mode_boot}, 32'h1);
    chk("t6_cpu_resetq", {31'h0, cpu_resetq}, 32'h0);
`ifdef RCPU_ARB_STATS_EN
    chk("t6_wait_clr", {16'h0, ldr_wait_cnt}, 32'd0);
`endif

    begin_cycle();
    begin_cycle();
    #3;
    chk("ldr_q_drained", ldr_q.size(), 32'd0);
    chk("cpu_q_drained", cpu_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rcpu_mem_arbiter.md
Name: rcpu_mem_arbiter

Overview:
- Shares the RCPU program/data memory between the CPU core and a second requester: a loader/DMA port fed by a UART bootloader or debug bridge.
- Memory has a separate read port and write port; each port carries one access per cycle, and read data is registered with 1-cycle latency.
- The CPU has no stall input, so it always has absolute priority. The loader is served only in slots the CPU leaves free.
- A BOOT mode holds the CPU in reset and gives the loader exclusive access, so program images can be written before execution starts.

Parameters:
- AW, 16, address width of memory and both requesters.
- DW, 16, data width.
- BOOT_ON_RESET, 1, 1 = enter BOOT after reset; 0 = enter RUN directly.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cpu_resetq  out  1  active-low reset to the CPU core; 0 while in BOOT.
- cpu_rd_en  in  1  CPU read enable.
- cpu_rd_addr  in  AW  CPU read address.
- cpu_rd_data  out  DW  equals mem_rd_data, pass-through.
- cpu_wr_en  in  1  CPU write enable.
- cpu_wr_addr  in  AW  CPU write address.
- cpu_wr_data  in  DW  CPU write data.
- ldr_req  in  1  loader request; held until granted.
- ldr_we  in  1  1 = write, 0 = read; qualified by ldr_req.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_gnt  out  1  one-cycle pulse: loader access issued this cycle.
- ldr_rvalid  out  1  registered; high exactly 1 cycle after a granted loader read.
- ldr_rdata  out  DW  equals mem_rd_data; valid when ldr_rvalid=1.
- ldr_done  in  1  pulse: loader finished; BOOT -> RUN.
- boot_req  in  1  pulse: RUN -> BOOT, which re-asserts CPU reset.
- mode_boot  out  1  1 while in BOOT.
- mem_rd_en  out  1  to RAM read port.
- mem_rd_addr  out  AW  to RAM read port.
- mem_rd_data  in  DW  from RAM, 1 cycle after address.
- mem_wr_en  out  1  to RAM write port.
- mem_wr_addr  out  AW  to RAM write port.
- mem_wr_data  out  DW  to RAM write port.

Behaviour:
- Reset:
  - mode = BOOT if BOOT_ON_RESET, else RUN.
  - cpu_resetq = !mode_boot.
  - ldr_gnt = 0, ldr_rvalid = 0, mem_rd_en = 0, mem_wr_en = 0.
  - Any in-flight loader read is discarded: ldr_rvalid stays 0.
- States:
  - BOOT: cpu_resetq = 0; CPU inputs ignored; the loader owns both ports.
  - RUN: cpu_resetq = 1; the CPU owns a port whenever it asserts that port's enable.
- Transitions:
  - BOOT -> RUN on ldr_done, registered; the CPU sees cpu_resetq = 1 from the next cycle.
  - RUN -> BOOT on boot_req. ldr_done and boot_req in the same cycle: boot_req wins.
- Grant rule, combinational in the current cycle:
  - loader write granted iff ldr_req & ldr_we & (BOOT | !cpu_wr_en).
  - loader read granted iff ldr_req & !ldr_we & (BOOT | !cpu_rd_en).
  - ldr_gnt asserts in the same cycle the access is driven onto the mem_* port.
- Read port mux:
  - CPU read drives mem_rd_addr/en when RUN & cpu_rd_en; otherwise the granted loader read.
  - mem_rd_en = 0 when neither requester is driving.
- Write port mux:
  - CPU write drives mem_wr_* when RUN & cpu_wr_en; otherwise the granted loader write.
  - mem_wr_en is never asserted for a non-granted requester.
- Loader read response: ldr_rvalid <= granted loader read. rdata is not held beyond that cycle.
- CPU reads always hit cpu_rd_data 1 cycle later. The arbiter adds zero latency and zero stalls to the CPU.
- A loader read followed by a CPU read in the next cycle is legal: each response cycle belongs to its own issuer.
- In RUN, a CPU that holds cpu_rd_en high continuously starves loader reads; loader writes still proceed in CPU write-idle cycles.
- A mode change mid-request does not cancel ldr_req; the request is re-arbitrated under the new mode.
- Widths are equal throughout; no truncation.

Optional Feature:
- Macro: RCPU_ARB_STATS_EN.
- When defined, adds output ldr_wait_cnt [15:0]:
  - increments each cycle ldr_req=1 and ldr_gnt=0;
  - saturates at 16'hFFFF;
  - clears on reset and on boot_req.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
1. BOOT_ON_RESET=1: release reset, loader writes 16'hBEEF to 0x0005, then pulses ldr_done.
   - cpu_resetq=0 until the cycle after ldr_done.
   - The CPU then reads 0x0005 and sees cpu_rd_data=16'hBEEF one cycle after the address.
2. RUN: cpu_wr_en=1 (0x0010 <= 16'h1234) in the same cycle as loader write 0x0011 <= 16'h5678.
   - The CPU write goes first and ldr_gnt=0 in that cycle.
   - Next cycle, with cpu_wr_en=0, ldr_gnt=1; both locations hold the expected values afterwards.
3. RUN with cpu_rd_en=0: loader read of 0x0011.
   - ldr_gnt=1 in the issue cycle.
   - ldr_rvalid=1 with ldr_rdata=16'h5678 exactly one cycle later.
4. RUN with cpu_rd_en stuck at 1 for 20 cycles and a loader read pending.
   - ldr_gnt stays 0 throughout.
   - With RCPU_ARB_STATS_EN, ldr_wait_cnt=20; after cpu_rd_en drops, the grant occurs.
5. Loader read granted, reset asserted in the next cycle.
   - ldr_rvalid=0; mode returns to BOOT and cpu_resetq=0.
6. RUN: boot_req and ldr_done pulsed in the same cycle.
   - mode_boot=1 next cycle and cpu_resetq=0.
